// File: rtl/aurora_block_sync_multi_if.sv
`default_nettype none
// ============================================================================
// Interface : aurora_block_sync_multi_if
// Header/enable bundle into the multi-lane block synchroniser and its status.
// Macro     : AURORA_SYNC_STATS_EN adds the per-lane slip/drop count buses.
// Revision  : 1.0
// ============================================================================
interface aurora_block_sync_multi_if #(
  parameter int NUM_LANES = 4
);
  logic [2*NUM_LANES-1:0] hdr_i;
  logic [NUM_LANES-1:0]   hdr_valid_i;
  logic [NUM_LANES-1:0]   enable_i;
  logic [NUM_LANES-1:0]   slip_o;
  logic [NUM_LANES-1:0]   locked_o;
  logic                   all_locked_o;
  logic [NUM_LANES-1:0]   sync_fail_o;
`ifdef AURORA_SYNC_STATS_EN
  logic [8*NUM_LANES-1:0] slip_cnt_o;
  logic [8*NUM_LANES-1:0] drop_cnt_o;

  modport master (
    output hdr_i, hdr_valid_i, enable_i,
    input  slip_o, locked_o, all_locked_o, sync_fail_o, slip_cnt_o, drop_cnt_o
  );
  modport slave (
    input  hdr_i, hdr_valid_i, enable_i,
    output slip_o, locked_o, all_locked_o, sync_fail_o, slip_cnt_o, drop_cnt_o
  );
`else
  modport master (
    output hdr_i, hdr_valid_i, enable_i,
    input  slip_o, locked_o, all_locked_o, sync_fail_o
  );
  modport slave (
    input  hdr_i, hdr_valid_i, enable_i,
    output slip_o, locked_o, all_locked_o, sync_fail_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/aurora_block_sync_multi.sv
`default_nettype none
// ============================================================================
// Module   : aurora_block_sync_multi
// Per-lane 64b/66b sync-header hunt/slip/lock with windowed lock-loss detect.
// Macro    : AURORA_SYNC_STATS_EN adds saturating slip and drop counters.
// Revision : 1.0
// ============================================================================
module aurora_block_sync_multi #(
  parameter int NUM_LANES  = 4,
  parameter int LOCK_CNT   = 64,
  parameter int SLIP_WAIT  = 16,
  parameter int ERR_WINDOW = 64,
  parameter int ERR_MAX    = 16,
  parameter int SLIP_FAIL  = 132
) (
  input  logic clk_rx_i,
  input  logic rst_i,
  aurora_block_sync_multi_if.slave bus
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam int NW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam int AW = $clog2(SLIP_FAIL + 1);

  localparam logic [GW-1:0] c_lock_cnt  = GW'(LOCK_CNT);
  localparam logic [WW-1:0] c_wait_last = WW'(SLIP_WAIT - 1);
  localparam logic [NW-1:0] c_win_last  = NW'(ERR_WINDOW - 1);
  localparam logic [EW-1:0] c_err_max   = EW'(ERR_MAX);
  localparam logic [AW-1:0] c_slip_fail = AW'(SLIP_FAIL);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  wire [NUM_LANES-1:0]   slip_w;
  wire [NUM_LANES-1:0]   locked_w;
  wire [NUM_LANES-1:0]   sync_fail_w;
`ifdef AURORA_SYNC_STATS_EN
  wire [8*NUM_LANES-1:0] slip_cnt_w;
  wire [8*NUM_LANES-1:0] drop_cnt_w;
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [1:0]    hdr;
    logic          hv;
    logic          en;
    logic          hdr_bad;
    logic          slip_set;
    logic          drop_evt;
    logic [GW-1:0] good_d;
    logic [EW-1:0] err_d;
    logic [AW-1:0] attempt_d;

    state_t        state_q;
    logic [GW-1:0] good_cnt_q;
    logic [WW-1:0] wait_cnt_q;
    logic [NW-1:0] win_cnt_q;
    logic [EW-1:0] err_cnt_q;
    logic [AW-1:0] attempt_cnt_q;
    logic          slip_q;
    logic          locked_q;
    logic          sync_fail_q;

    assign hdr       = bus.hdr_i[2*g +: 2];
    assign hv        = bus.hdr_valid_i[g];
    assign en        = bus.enable_i[g];
    assign hdr_bad   = ~(hdr[1] ^ hdr[0]);
    assign good_d    = good_cnt_q + 1'b1;
    assign err_d     = err_cnt_q + EW'(hdr_bad);
    assign attempt_d = (attempt_cnt_q == c_slip_fail) ? attempt_cnt_q : attempt_cnt_q + 1'b1;
    assign slip_set  = en && hv && hdr_bad && (state_q == ST_HUNT);
    assign drop_evt  = en && hv && (state_q == ST_LOCKED) && (err_d == c_err_max);

    // A disabled lane is held exactly as if in reset.
    always_ff @(posedge clk_rx_i) begin
      if (rst_i || !en) begin
        state_q       <= ST_HUNT;
        good_cnt_q    <= '0;
        wait_cnt_q    <= '0;
        win_cnt_q     <= '0;
        err_cnt_q     <= '0;
        attempt_cnt_q <= '0;
        slip_q        <= 1'b0;
        locked_q      <= 1'b0;
        sync_fail_q   <= 1'b0;
      end else begin
        slip_q <= 1'b0;
        case (state_q)
          ST_HUNT: begin
            if (hv) begin
              if (hdr_bad) begin
                state_q    <= ST_SLIP;
                slip_q     <= 1'b1;
                good_cnt_q <= '0;
              end else if (good_d == c_lock_cnt) begin
                state_q       <= ST_LOCKED;
                locked_q      <= 1'b1;
                good_cnt_q    <= '0;
                win_cnt_q     <= '0;
                err_cnt_q     <= '0;
                attempt_cnt_q <= '0;
                sync_fail_q   <= 1'b0;
              end else begin
                good_cnt_q <= good_d;
              end
            end
          end
          ST_SLIP: begin
            state_q       <= ST_WAIT;
            wait_cnt_q    <= '0;
            attempt_cnt_q <= attempt_d;
            if (attempt_d == c_slip_fail) begin
              sync_fail_q <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (hv) begin
              if (wait_cnt_q == c_wait_last) begin
                state_q    <= ST_HUNT;
                wait_cnt_q <= '0;
                good_cnt_q <= '0;
              end else begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
              end
            end
          end
          ST_LOCKED: begin
            // Reaching the error limit on the last window beat still drops lock.
            if (hv) begin
              if (err_d == c_err_max) begin
                state_q   <= ST_HUNT;
                locked_q  <= 1'b0;
                win_cnt_q <= '0;
                err_cnt_q <= '0;
              end else if (win_cnt_q == c_win_last) begin
                win_cnt_q <= '0;
                err_cnt_q <= '0;
              end else begin
                win_cnt_q <= win_cnt_q + 1'b1;
                err_cnt_q <= err_d;
              end
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end

    assign slip_w[g]      = slip_q;
    assign locked_w[g]    = locked_q;
    assign sync_fail_w[g] = sync_fail_q;

`ifdef AURORA_SYNC_STATS_EN
    logic [7:0] slip_cnt_q;
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk_rx_i) begin
      if (rst_i) begin
        slip_cnt_q <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (slip_set && (slip_cnt_q != 8'hFF)) begin
          slip_cnt_q <= slip_cnt_q + 8'd1;
        end
        if (drop_evt && (drop_cnt_q != 8'hFF)) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end

    assign slip_cnt_w[8*g +: 8] = slip_cnt_q;
    assign drop_cnt_w[8*g +: 8] = drop_cnt_q;
`endif
  end

  logic all_locked_q;

  always_ff @(posedge clk_rx_i) begin
    if (rst_i) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= (|bus.enable_i) && (&(locked_w | ~bus.enable_i));
    end
  end

  assign bus.slip_o       = slip_w;
  assign bus.locked_o     = locked_w;
  assign bus.sync_fail_o  = sync_fail_w;
  assign bus.all_locked_o = all_locked_q;
`ifdef AURORA_SYNC_STATS_EN
  assign bus.slip_cnt_o   = slip_cnt_w;
  assign bus.drop_cnt_o   = drop_cnt_w;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aurora_block_sync_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_aurora_block_sync_multi
// Directed self-checking bench for aurora_block_sync_multi (4 lanes).
// Revision : 1.0
// ============================================================================
module tb_aurora_block_sync_multi;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aurora_block_sync_multi_if #(.NUM_LANES(NL)) bus ();

  aurora_block_sync_multi #(.NUM_LANES(NL)) dut (
    .clk_rx_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // mode: 0 aligned random 01/10, 1 gearbox model at offset gk, 2 constant 2'b11
  int          mode      [NL];
  logic        inj       [NL];
  int          slips     [NL];
  int          last_slip [NL];
  int          min_gap   [NL];
  int          drops     [NL];
  int          cyc;
  int          win0;
  int          gk;
  logic [NL-1:0] prev_locked;
  logic [65:0] cur_blk;
  logic [65:0] nxt_blk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [65:0] new_blk();
    logic [1:0] h;
    h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    return {h, $urandom(), $urandom()};
  endfunction

  function automatic logic gb_bit(input int p);
    if (p < 66) return cur_blk[65 - p];
    return nxt_blk[65 - (p - 66)];
  endfunction

  task automatic clr_stats();
    for (int l = 0; l < NL; l++) begin
      slips[l] = 0; last_slip[l] = -1; min_gap[l] = 1000000; drops[l] = 0;
    end
  endtask

  task automatic step();
    logic [1:0] h;
    for (int l = 0; l < NL; l++) begin
      case (mode[l])
        1:       h = {gb_bit(gk), gb_bit(gk + 1)};
        2:       h = 2'b11;
        default: h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      endcase
      if (inj[l]) h = 2'b00;
      inj[l] = 1'b0;
      bus.hdr_i[2*l +: 2] = h;
    end
    prev_locked = bus.locked_o;
    @(posedge clk);
    #1;
    cyc++;
    cur_blk = nxt_blk;
    nxt_blk = new_blk();
    for (int l = 0; l < NL; l++) begin
      if (bus.slip_o[l]) begin
        slips[l]++;
        if (last_slip[l] >= 0 && (cyc - last_slip[l]) < min_gap[l]) min_gap[l] = cyc - last_slip[l];
        last_slip[l] = cyc;
        if (mode[l] == 1) gk = (gk + 1) % 66;
      end
      if (prev_locked[l] && !bus.locked_o[l]) drops[l]++;
    end
    if (prev_locked[0]) win0 = (win0 + 1) % 64;
    else if (bus.locked_o[0]) win0 = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic adv_to(input int target);
    int n;
    n = 0;
    while (win0 != target && n < 200) begin
      step();
      n++;
    end
    chk("adv_to_window", 32'(win0), 32'(target));
  endtask

  task automatic wait_lock(input int lane, input int limit, input string tag);
    int n;
    n = 0;
    while (!bus.locked_o[lane] && n < limit) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.locked_o[lane]), 32'd1);
  endtask

  task automatic wait_slips(input int lane, input int target, input string tag);
    int n;
    n = 0;
    while (slips[lane] < target && n < 8000) begin
      step();
      n++;
    end
    chk(tag, 32'(slips[lane]), 32'(target));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},     32'(bus.locked_o),     32'd0);
    chk({tag, "_slip"},       32'(bus.slip_o),       32'd0);
    chk({tag, "_all_locked"}, 32'(bus.all_locked_o), 32'd0);
    chk({tag, "_sync_fail"},  32'(bus.sync_fail_o),  32'd0);
`ifdef AURORA_SYNC_STATS_EN
    chk({tag, "_slip_cnt"},   bus.slip_cnt_o,        32'd0);
    chk({tag, "_drop_cnt"},   bus.drop_cnt_o,        32'd0);
`endif
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s3;
    cyc = 0; win0 = 0; gk = 0;
    cur_blk = new_blk();
    nxt_blk = new_blk();
    for (int l = 0; l < NL; l++) begin
      mode[l] = 0; inj[l] = 1'b0;
    end
    clr_stats();
    bus.hdr_i       = '0;
    bus.hdr_valid_i = '1;
    bus.enable_i    = '1;

    // Reset state
    rst = 1'b1;
    steps(3);
    chk_all_zero("reset");

    // hdr_valid low: headers ignored even when invalid
    rst = 1'b0;
    bus.hdr_valid_i = '0;
    for (int l = 0; l < NL; l++) mode[l] = 2;
    steps(5);
    chk("hv_low_no_slip", 32'(slips[0] + slips[1] + slips[2] + slips[3]), 32'd0);
    bus.hdr_valid_i = '1;
    for (int l = 0; l < NL; l++) mode[l] = 0;

    // Aligned stream: lock one cycle after 64th beat, all_locked one later
    steps(63);
    chk("aligned_63_not_locked", 32'(bus.locked_o), 32'd0);
    step();
    chk("aligned_64_locked", 32'(bus.locked_o), 32'hF);
    chk("aligned_all_locked_lag", 32'(bus.all_locked_o), 32'd0);
    step();
    chk("aligned_all_locked", 32'(bus.all_locked_o), 32'd1);
    chk("aligned_no_slip", 32'(slips[0] + slips[1] + slips[2] + slips[3]), 32'd0);

    // Lane 1 starts 17 bits misaligned: 49 slips back to offset 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    clr_stats();
    gk = 17;
    mode[1] = 1;
    wait_lock(1, 3000, "misalign_lane1_lock");
    chk("misalign_slip_count", 32'(slips[1]), 32'd49);
    chk("misalign_offset", 32'(gk), 32'd0);
    chk("misalign_slip_gap", 32'(min_gap[1] >= 18), 32'd1);
    chk("misalign_other_slips", 32'(slips[0] + slips[2] + slips[3]), 32'd0);
    chk("misalign_all_lanes", 32'(bus.locked_o), 32'hF);
`ifdef AURORA_SYNC_STATS_EN
    chk("misalign_slip_cnt1", 32'(bus.slip_cnt_o[15:8]), 32'd49);
`endif
    mode[1] = 0;
    step();
    chk("misalign_all_locked", 32'(bus.all_locked_o), 32'd1);

    // 15 invalid per 64 beats for 10 windows: no drop for any window phase
    for (int i = 0; i < 640; i++) begin
      inj[0] = ((i % 64) < 15);
      step();
    end
    chk("err15_no_drop", 32'(drops[0]), 32'd0);
    chk("err15_locked", 32'(bus.locked_o[0]), 32'd1);

    // 15 errors at end of a window, wrap clears, one more error next window
    adv_to(0);
    adv_to(49);
    for (int i = 0; i < 15; i++) begin
      inj[0] = 1'b1;
      step();
    end
    chk("wrap_15_locked", 32'(bus.locked_o[0]), 32'd1);
    inj[0] = 1'b1;
    step();
    chk("wrap_cleared_locked", 32'(bus.locked_o[0]), 32'd1);

    // 16th error lands on the final window beat: drop wins over clear
    adv_to(0);
    adv_to(48);
    for (int i = 0; i < 15; i++) begin
      inj[0] = 1'b1;
      step();
    end
    chk("drop_15_still_locked", 32'(bus.locked_o[0]), 32'd1);
    inj[0] = 1'b1;
    step();
    chk("drop_final_beat", 32'(bus.locked_o[0]), 32'd0);
    chk("drop_no_slip", 32'(bus.slip_o[0]), 32'd0);
    chk("drop_count", 32'(drops[0]), 32'd1);
`ifdef AURORA_SYNC_STATS_EN
    chk("drop_cnt0", 32'(bus.drop_cnt_o[7:0]), 32'd1);
`endif
    wait_lock(0, 100, "drop_relock");
    chk("drop_relock_no_slip", 32'(slips[0]), 32'd0);

    // Constant 2'b11 on lane 2: drop, endless slips, sync_fail at 132nd slip
    mode[2] = 2;
    wait_slips(2, 131, "l2_slip131");
    steps(10);
    chk("l2_sync_fail_131", 32'(bus.sync_fail_o[2]), 32'd0);
    wait_slips(2, 132, "l2_slip132");
    steps(2);
    chk("l2_sync_fail_132", 32'(bus.sync_fail_o[2]), 32'd1);
    chk("l2_slip_gap", 32'(min_gap[2]), 32'd18);
    chk("l2_drop", 32'(drops[2]), 32'd1);
    wait_slips(2, 260, "l2_slip260");
    chk("l2_sync_fail_holds", 32'(bus.sync_fail_o[2]), 32'd1);
`ifdef AURORA_SYNC_STATS_EN
    chk("l2_slip_cnt_sat", 32'(bus.slip_cnt_o[23:16]), 32'd255);
    chk("l2_drop_cnt", 32'(bus.drop_cnt_o[23:16]), 32'd1);
`endif
    mode[2] = 0;
    wait_lock(2, 200, "l2_relock");
    chk("l2_sync_fail_clear", 32'(bus.sync_fail_o[2]), 32'd0);
    step();
    chk("l2_all_locked", 32'(bus.all_locked_o), 32'd1);

    // enable_i[3] low while LOCKED
    bus.enable_i[3] = 1'b0;
    step();
    chk("dis_locked_l3", 32'(bus.locked_o[3]), 32'd0);
    chk("dis_locked_slip", 32'(bus.slip_o[3]), 32'd0);
    chk("dis_all_locked_0to2", 32'(bus.all_locked_o), 32'd1);
    bus.enable_i[3] = 1'b1;
    step();
    chk("reen_all_locked", 32'(bus.all_locked_o), 32'd0);

    // enable_i[3] low while WAIT
    inj[3] = 1'b1;
    step();
    chk("l3_slip_pulse", 32'(bus.slip_o[3]), 32'd1);
    s3 = slips[3];
    steps(4);
    bus.enable_i[3] = 1'b0;
    mode[3] = 2;
    step();
    chk("dis_wait_locked", 32'(bus.locked_o[3]), 32'd0);
    steps(30);
    chk("dis_wait_no_slip", 32'(slips[3]), 32'(s3));
    chk("dis_wait_all_locked", 32'(bus.all_locked_o), 32'd1);
`ifdef AURORA_SYNC_STATS_EN
    chk("dis_stats_hold", 32'(bus.slip_cnt_o[31:24]), 32'd1);
`endif
    bus.enable_i[3] = 1'b1;
    mode[3] = 0;
    wait_lock(3, 100, "l3_relock");
    step();
    chk("l3_all_locked", 32'(bus.all_locked_o), 32'd1);

    // Reset coincident with a slip pulse on lane 2 and a lane-0 window wrap
    adv_to(1);
    bus.enable_i[2] = 1'b0;
    step();
    bus.enable_i[2] = 1'b1;
    adv_to(62);
    inj[2] = 1'b1;
    step();
    chk("pre_rst_slip", 32'(bus.slip_o[2]), 32'd1);
    chk("pre_rst_win", 32'(win0), 32'd63);
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aurora_block_sync_multi.md
Name: aurora_block_sync_multi

Overview:
Multi-lane 64b/66b block-synchroniser. It watches the 2-bit sync headers that each lane's gearbox produces and pulses per-lane gearbox slip until header alignment is found. It declares lock and detects lane drop with a windowed error count. It sits between the per-lane gearboxes and the channel bonding/descrambler stage, and generalises the single-lane header lock in aurora_rx_lane to NUM_LANES lanes with programmable thresholds and a sync-failure flag.

Parameters:
NUM_LANES, 4, number of independent lanes
LOCK_CNT, 64, consecutive valid headers needed to declare lock
SLIP_WAIT, 16, hdr_valid beats ignored after each slip (gearbox settle)
ERR_WINDOW, 64, header beats per error-monitoring window while locked
ERR_MAX, 16, invalid headers within one window that force a lane drop
SLIP_FAIL, 132, slips without lock before sync_fail asserts (2 full 66-bit rotations)

Ports:
clk_rx_i  in  1  receive-domain clock
rst_i  in  1  reset, synchronous, active-high
hdr_i  in  2*NUM_LANES  sync header per lane, lane n at [2n+1:2n]
hdr_valid_i  in  NUM_LANES  header beat valid per lane
enable_i  in  NUM_LANES  lane enable; low holds lane in HUNT
slip_o  out  NUM_LANES  one-cycle gearbox slip pulse per lane
locked_o  out  NUM_LANES  lane block-locked
all_locked_o  out  1  AND of locked_o over enabled lanes; 0 if no lane enabled
sync_fail_o  out  NUM_LANES  lane exceeded SLIP_FAIL slips without lock
slip_cnt_o  out  8*NUM_LANES  per-lane saturating slip count (AURORA_SYNC_STATS_EN only)
drop_cnt_o  out  8*NUM_LANES  per-lane saturating lock-loss count (AURORA_SYNC_STATS_EN only)

Behaviour:
- Valid header: 2'b01 or 2'b10. Invalid: 2'b00 or 2'b11. Headers are evaluated only on hdr_valid_i beats.
- Reset: all outputs 0, every lane in HUNT, all counters 0.
- Per-lane FSM: HUNT, SLIP, WAIT, LOCKED. Lanes are fully independent.
- HUNT:
  - Valid beat: good_cnt+1.
  - Invalid beat: go to SLIP, good_cnt=0.
  - good_cnt reaching LOCK_CNT: go to LOCKED. locked_o=1 the cycle after the LOCK_CNT-th good beat.
- SLIP:
  - slip_o=1 for exactly one cycle, registered, so it appears the cycle after the invalid beat.
  - attempt_cnt+1, then go to WAIT.
- WAIT:
  - Count SLIP_WAIT hdr_valid beats with headers ignored, then HUNT with good_cnt=0.
  - slip_o is never asserted in WAIT.
- LOCKED:
  - win_cnt counts beats 0..ERR_WINDOW-1 and wraps. err_cnt counts invalid beats.
  - err_cnt reaching ERR_MAX: locked_o=0 the next cycle, go to HUNT, clear all counters, drop_cnt+1. No slip is issued on the drop itself.
  - Window wrap with err_cnt<ERR_MAX: err_cnt=0.
  - Invalid beat on the final window beat that makes err_cnt==ERR_MAX: the drop wins over the window clear.
- sync_fail_o:
  - Set when attempt_cnt reaches SLIP_FAIL. Hunting continues.
  - Cleared, together with attempt_cnt, on entry to LOCKED or on reset.
  - attempt_cnt saturates at SLIP_FAIL.
- enable_i low:
  - Lane goes to HUNT next cycle. locked_o, slip_o and sync_fail_o are forced to 0; FSM counters are cleared; stats counters hold.
  - A pending SLIP is cancelled.
- Reset mid-operation: everything returns to reset values the next edge, including an in-flight slip pulse.
- all_locked_o: registered, one cycle after the last locked_o rises.
- Stats counters: 8-bit, saturate at 255, never wrap.

Optional Feature:
AURORA_SYNC_STATS_EN:
- Defined: slip_cnt_o and drop_cnt_o ports and counters exist. slip_cnt increments on every slip_o pulse; drop_cnt on every LOCKED-to-HUNT drop. Both clear only on rst_i.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Aligned stream, all valid headers, NUM_LANES=4 → no slip_o; locked_o=4'hF after 64th beat +1 cycle; all_locked_o one cycle later.
- Lane 1 starts 17 bits misaligned (scrambled 66-bit blocks, 2'b01/2'b10 headers) → lane 1 slips, each slip followed by 16 ignored beats, then locks; lanes 0/2/3 unaffected.
- Locked lane gets 16 invalid headers in one 64-beat window → locked_o drops next cycle, drop_cnt=1; 15 invalid headers per window repeated 10 windows → stays locked.
- Constant header 2'b11 on lane 2 → slip_o pulses continue; sync_fail_o[2]=1 at 132nd slip; slip_cnt saturates at 255; switch to valid headers → locks, sync_fail_o[2] clears.
- enable_i[3] low mid-LOCKED and mid-WAIT → locked_o[3]=0 next cycle, no slip pulse, all_locked_o reflects lanes 0-2 only.
- rst_i asserted for 1 cycle coincident with a slip pulse and an error-window wrap → all outputs 0 next cycle; stats counters 0.
